// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states and default widths.
package exec_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_MUL_CYCLES = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/exec_unit_mul_iter.sv
// Iterative shift-add multiplier; result_o carries the final sum in the cycle done_o is high.
module mul_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [DATA_WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q;

    assign acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign done_o   = busy_q && (cnt_q == CNT_LAST);
    assign result_o = acc_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU, iterative multiply, registered register-file writeback.
module exec_unit
    import exec_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic [DATA_WIDTH-1:0] i_src_a,
    input  logic [DATA_WIDTH-1:0] i_src_b,
    output logic                  o_wb_en,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic                  o_ovf,
    output logic                  o_err
);
    state_t                state_q;
    logic                  ready_q, wb_en_q, ovf_q, err_q;
    logic [ADDR_WIDTH-1:0] wb_addr_q, rd_q;
    logic [DATA_WIDTH-1:0] wb_data_q;

    logic                  accept, op_legal, rd_nonzero, mul_done;
    logic [DATA_WIDTH-1:0] alu_res, mul_res;
    logic                  alu_ovf;
    logic [4:0]            shamt;

    assign accept     = i_valid && ready_q;
    assign op_legal   = (i_op <= OP_MUL);
    assign rd_nonzero = (i_rd != '0);
    assign shamt      = i_src_b[4:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (i_op)
            OP_ADD: begin
                alu_res = i_src_a + i_src_b;
                alu_ovf = (i_src_a[DATA_WIDTH-1] == i_src_b[DATA_WIDTH-1]) &&
                          (alu_res[DATA_WIDTH-1] != i_src_a[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = i_src_a - i_src_b;
                alu_ovf = (i_src_a[DATA_WIDTH-1] != i_src_b[DATA_WIDTH-1]) &&
                          (alu_res[DATA_WIDTH-1] != i_src_a[DATA_WIDTH-1]);
            end
            OP_AND: alu_res = i_src_a & i_src_b;
            OP_OR:  alu_res = i_src_a | i_src_b;
            OP_XOR: alu_res = i_src_a ^ i_src_b;
            OP_SLT: alu_res[0] = ($signed(i_src_a) < $signed(i_src_b));
            OP_SLL: alu_res = i_src_a << shamt;
            OP_SRL: alu_res = i_src_a >> shamt;
            OP_SRA: alu_res = $unsigned($signed(i_src_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    mul_iter #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk_i    (i_clk),
        .rst_n_i  (i_rst_n),
        .start_i  (accept && (i_op == OP_MUL)),
        .a_i      (i_src_a),
        .b_i      (i_src_b),
        .done_o   (mul_done),
        .result_o (mul_res)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            wb_en_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE, WB: begin
                    state_q <= IDLE;
                    if (accept) begin
                        if (!op_legal) begin
                            err_q <= 1'b1;
                        end else if (i_op == OP_MUL) begin
                            rd_q    <= i_rd;
                            ready_q <= 1'b0;
                            state_q <= MUL;
                        end else begin
                            // x0 writes are suppressed but the result is still presented
                            wb_en_q   <= rd_nonzero;
                            wb_addr_q <= i_rd;
                            wb_data_q <= alu_res;
                            ovf_q     <= alu_ovf && rd_nonzero;
                            state_q   <= WB;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        wb_en_q   <= (rd_q != '0);
                        wb_addr_q <= rd_q;
                        wb_data_q <= mul_res;
                        ready_q   <= 1'b1;
                        state_q   <= WB;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ready   = ready_q;
    assign o_wb_en   = wb_en_q;
    assign o_wb_addr = wb_addr_q;
    assign o_wb_data = wb_data_q;
    assign o_ovf     = ovf_q;
    assign o_err     = err_q;

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the register file.
- Consumes the two read operands (rs1/rs2 data) plus a decoded opcode and destination index.
- Computes single-cycle ALU results and an iterative 32-cycle multiply.
- Drives the register-file write port (enable/address/data) with a registered writeback.

Parameters:
ADDR_WIDTH, 5, register index width (matches register file)
DATA_WIDTH, 32, operand/result width
MUL_CYCLES, 32, multiply iterations; must equal DATA_WIDTH

Ports:
i_clk      input   1           clock, all state on rising edge
i_rst_n    input   1           asynchronous active-low reset
i_valid    input   1           operation presented this cycle
o_ready    output  1           unit can accept; transfer when i_valid && o_ready
i_op       input   4           opcode (see Behaviour)
i_rd       input   ADDR_WIDTH  destination register index
i_src_a    input   DATA_WIDTH  operand A (register-file port A data)
i_src_b    input   DATA_WIDTH  operand B (register-file port B data)
o_wb_en    output  1           register-file write enable, one-cycle pulse
o_wb_addr  output  ADDR_WIDTH  register-file write address
o_wb_data  output  DATA_WIDTH  register-file write data
o_ovf      output  1           signed overflow of ADD/SUB, qualified by o_wb_en
o_err      output  1           one-cycle pulse: illegal opcode accepted

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state=IDLE; o_ready=1; o_wb_en=0; o_wb_addr=0; o_wb_data=0; o_ovf=0; o_err=0; multiply counter and accumulator=0.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed; result 1 or 0, zero-extended.
  - 6 SLL, 7 SRL, 8 SRA: shift amount = i_src_b[4:0].
  - 9 MUL: low DATA_WIDTH bits of the product (identical for signed and unsigned).
  - 10-15 illegal.
- All arithmetic is DATA_WIDTH wrap-around.
- o_ovf rules:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
  - All other ops: o_ovf = 0.
- FSM states: IDLE, MUL, WB.
  - IDLE, o_ready=1:
    - Accept ALU op → result registered, state=WB.
    - Accept MUL → load multiplicand=A, multiplier=B, acc=0, cnt=0, state=MUL.
    - Accept illegal op → o_err=1 next cycle, no write, stay IDLE.
  - MUL, o_ready=0:
    - Each cycle: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, cnt++.
    - After cnt reaches MUL_CYCLES-1, go to WB with o_wb_data=acc.
  - WB, o_ready=1: o_wb_en is high for exactly this cycle. A same-cycle accept behaves as it does from IDLE, which allows back-to-back ALU ops. With no accept, return to IDLE.
- Latency (accept on edge N):
  - ALU op: o_wb_en high in cycle N+1.
  - MUL: o_wb_en high in cycle N+1+MUL_CYCLES, i.e. N+33.
- Throughput: one ALU op per cycle; MUL blocks for MUL_CYCLES+1 cycles.
- x0 rule: when i_rd==0, the op executes but o_wb_en stays 0. o_wb_addr and o_wb_data still update.
- i_valid while o_ready=0: ignored. Upstream holds its inputs; nothing is latched.
- o_wb_addr/o_wb_data hold their last values when o_wb_en=0.
- Reset mid-multiply: immediate return to IDLE, no writeback pulse, result discarded.
- i_src_a and i_src_b are sampled only at accept. Later changes (including a write to the same register) do not affect an in-flight MUL.

Decomposition:
- Shared package exec_pkg: opcode localparams OP_ADD..OP_MUL, state encoding IDLE/MUL/WB, DATA_WIDTH/ADDR_WIDTH defaults.
- One sub-module: mul_iter (shift-add core with start/busy/done and cnt).
- exec_unit keeps the FSM, the combinational ALU and the writeback registers.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF B=1 rd=3 → next cycle o_wb_en=1, addr=3, data=0x80000000, o_ovf=1.
- Back-to-back SUB 5-7 rd=1, SRA 0x80000000>>4 rd=2, SLT -1<1 rd=4 → three consecutive o_wb_en pulses: 0xFFFFFFFE, 0xF8000000, 0x00000001.
- MUL A=0xFFFFFFFF B=3 rd=5 accepted at cycle N → o_ready=0 for cycles N+1..N+32, o_wb_en only at N+33, data=0xFFFFFFFD; i_valid asserted during the busy window is ignored.
- ADD 4+4 with rd=0 → o_wb_en stays 0, o_wb_data=8; illegal op 12 rd=7 → o_err pulse 1 cycle, no write.
- MUL 1234*5678 with i_rst_n pulled low at cycle N+10 → all outputs return to reset values asynchronously, no o_wb_en pulse after release, o_ready=1.
